// File: rtl/br_seq_ctrl.sv
// -----------------------------------------------------------------------------
// br_seq_ctrl -- microsequencer for a small LC-3 style datapath.
//
// Walks the fetch / decode / execute sequence. All outputs are decoded from
// state and registered (decoded from the next state, so they line up with the
// state they belong to). The one exception is LD_MDR. It must follow Mem_Rdy
// in the same cycle that FETCH2 sees valid data, so it is gated combinationally
// from the registered Mem_OE.
//
// Build option:
//    PAUSE_OP_EN  when defined, opcode 1101 enters a two-step pause handshake
//                 driven by Continue. When undefined, 1101 is a NOP, Paused is
//                 tied low and Continue is ignored.
//
// Ports:
//    Clk        in   system clock, rising edge
//    Reset      in   synchronous active-high reset
//    Run        in   start request, sampled only in HALTED
//    Continue   in   pause release handshake
//    Opcode     in   [3:0] IR[15:12]
//    BEN        in   branch enable, sampled only in BR0
//    Mem_Rdy    in   memory read data valid, sampled only in FETCH2
//    LD_*       out  register load strobes
//    Gate*      out  bus drivers, one-hot or zero
//    PCMUX      out  [1:0] 00 PC+1, 01 PC+off9, 10 BaseR
//    ALUK       out  [1:0] 00 ADD, 01 AND, 10 NOT
//    Mem_OE     out  memory read enable
//    Paused     out  high while holding in a pause state
//
// state   | meaning
// --------+--------------------------------------------------
// HALTED  | idle, waiting for Run
// FETCH1  | MAR <- PC, PC <- PC+1
// FETCH2  | memory read, wait for Mem_Rdy (no timeout)
// FETCH3  | IR <- MDR
// DECODE  | latch BEN, dispatch on Opcode
// EX_ADD  | ALU ADD into register file, set CC
// EX_AND  | ALU AND into register file, set CC
// EX_NOT  | ALU NOT into register file, set CC
// BR0     | branch test on BEN
// BR1     | taken branch, PC <- PC+off9
// JMP     | PC <- BaseR
// PAUSE1  | paused, wait for Continue high
// PAUSE2  | paused, wait for Continue low
// -----------------------------------------------------------------------------
module br_seq_ctrl (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic [3:0] Opcode,
   input  logic       BEN,
   input  logic       Mem_Rdy,
   output logic       LD_MAR,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       LD_BEN,
   output logic       LD_CC,
   output logic       LD_REG,
   output logic       LD_PC,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       GateALU,
   output logic [1:0] PCMUX,
   output logic [1:0] ALUK,
   output logic       Mem_OE,
   output logic       Paused
);

   typedef enum logic [3:0] {
      S_HALTED = 4'd0,
      S_FETCH1 = 4'd1,
      S_FETCH2 = 4'd2,
      S_FETCH3 = 4'd3,
      S_DECODE = 4'd4,
      S_EX_ADD = 4'd5,
      S_EX_AND = 4'd6,
      S_EX_NOT = 4'd7,
      S_BR0    = 4'd8,
      S_BR1    = 4'd9,
      S_JMP    = 4'd10
`ifdef PAUSE_OP_EN
      ,
      S_PAUSE1 = 4'd11,
      S_PAUSE2 = 4'd12
`endif
   } state_t;

   state_t     state_q;
   state_t     state_d;

   logic       ld_mar_d, ld_ir_d, ld_ben_d, ld_cc_d, ld_reg_d, ld_pc_d;
   logic       gate_pc_d, gate_mdr_d, gate_alu_d, mem_oe_d;
   logic [1:0] pcmux_d, aluk_d;

   always_comb begin
      state_d = S_HALTED;
      case (state_q)
         S_HALTED: state_d = Run ? S_FETCH1 : S_HALTED;
         S_FETCH1: state_d = S_FETCH2;
         S_FETCH2: state_d = Mem_Rdy ? S_FETCH3 : S_FETCH2;
         S_FETCH3: state_d = S_DECODE;
         S_DECODE: begin
            case (Opcode)
               4'b0001: state_d = S_EX_ADD;
               4'b0101: state_d = S_EX_AND;
               4'b1001: state_d = S_EX_NOT;
               4'b0000: state_d = S_BR0;
               4'b1100: state_d = S_JMP;
`ifdef PAUSE_OP_EN
               4'b1101: state_d = S_PAUSE1;
`endif
               default: state_d = S_FETCH1;
            endcase
         end
         S_EX_ADD: state_d = S_FETCH1;
         S_EX_AND: state_d = S_FETCH1;
         S_EX_NOT: state_d = S_FETCH1;
         S_BR0:    state_d = BEN ? S_BR1 : S_FETCH1;
         S_BR1:    state_d = S_FETCH1;
         S_JMP:    state_d = S_FETCH1;
`ifdef PAUSE_OP_EN
         S_PAUSE1: state_d = Continue ? S_PAUSE2 : S_PAUSE1;
         S_PAUSE2: state_d = Continue ? S_PAUSE2 : S_FETCH1;
`endif
         default:  state_d = S_HALTED;
      endcase
   end

   // Output decode of the state being entered; registered below.
   always_comb begin
      ld_mar_d   = 1'b0;
      ld_ir_d    = 1'b0;
      ld_ben_d   = 1'b0;
      ld_cc_d    = 1'b0;
      ld_reg_d   = 1'b0;
      ld_pc_d    = 1'b0;
      gate_pc_d  = 1'b0;
      gate_mdr_d = 1'b0;
      gate_alu_d = 1'b0;
      mem_oe_d   = 1'b0;
      pcmux_d    = 2'b00;
      aluk_d     = 2'b00;
      case (state_d)
         S_FETCH1: begin
            gate_pc_d = 1'b1;
            ld_mar_d  = 1'b1;
            ld_pc_d   = 1'b1;
         end
         S_FETCH2: mem_oe_d = 1'b1;
         S_FETCH3: begin
            gate_mdr_d = 1'b1;
            ld_ir_d    = 1'b1;
         end
         S_DECODE: ld_ben_d = 1'b1;
         S_EX_ADD, S_EX_AND, S_EX_NOT: begin
            gate_alu_d = 1'b1;
            ld_reg_d   = 1'b1;
            ld_cc_d    = 1'b1;
            aluk_d     = (state_d == S_EX_AND) ? 2'b01 :
                         (state_d == S_EX_NOT) ? 2'b10 : 2'b00;
         end
         S_BR1: begin
            ld_pc_d = 1'b1;
            pcmux_d = 2'b01;
         end
         S_JMP: begin
            ld_pc_d = 1'b1;
            pcmux_d = 2'b10;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_HALTED;
         LD_MAR  <= 1'b0;
         LD_IR   <= 1'b0;
         LD_BEN  <= 1'b0;
         LD_CC   <= 1'b0;
         LD_REG  <= 1'b0;
         LD_PC   <= 1'b0;
         GatePC  <= 1'b0;
         GateMDR <= 1'b0;
         GateALU <= 1'b0;
         PCMUX   <= 2'b00;
         ALUK    <= 2'b00;
         Mem_OE  <= 1'b0;
      end else begin
         state_q <= state_d;
         LD_MAR  <= ld_mar_d;
         LD_IR   <= ld_ir_d;
         LD_BEN  <= ld_ben_d;
         LD_CC   <= ld_cc_d;
         LD_REG  <= ld_reg_d;
         LD_PC   <= ld_pc_d;
         GatePC  <= gate_pc_d;
         GateMDR <= gate_mdr_d;
         GateALU <= gate_alu_d;
         PCMUX   <= pcmux_d;
         ALUK    <= aluk_d;
         Mem_OE  <= mem_oe_d;
      end
   end

   // Mem_OE is high only in FETCH2, so this strobes MDR exactly on the
   // cycle the read data becomes valid.
   assign LD_MDR = Mem_OE & Mem_Rdy;

`ifdef PAUSE_OP_EN
   logic paused_q;

   always_ff @(posedge Clk) begin
      if (Reset) paused_q <= 1'b0;
      else       paused_q <= (state_d == S_PAUSE1) || (state_d == S_PAUSE2);
   end

   assign Paused = paused_q;
`else
   logic unused_continue;

   assign unused_continue = Continue;
   assign Paused          = 1'b0;
`endif

endmodule

// File: tb/tb_br_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_br_seq_ctrl -- self-checking bench for br_seq_ctrl.
//
// The reference model builds, per instruction, the list of per-cycle output
// words the datapath should see (fetch, memory wait, decode, execute), along
// with the inputs that matter in that cycle. Every input that the sequencer
// must ignore in a given cycle is randomised.
// Output word: {LD_MAR,LD_MDR,LD_IR,LD_BEN,LD_CC,LD_REG,LD_PC,GatePC,GateMDR,
//               GateALU,PCMUX[1:0],ALUK[1:0],Mem_OE,Paused}
// -----------------------------------------------------------------------------
module tb_br_seq_ctrl;

   logic       Clk;
   logic       Reset;
   logic       Run;
   logic       Continue;
   logic [3:0] Opcode;
   logic       BEN;
   logic       Mem_Rdy;
   logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
   logic       GatePC, GateMDR, GateALU;
   logic [1:0] PCMUX, ALUK;
   logic       Mem_OE, Paused;

   br_seq_ctrl dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Run      (Run),
      .Continue (Continue),
      .Opcode   (Opcode),
      .BEN      (BEN),
      .Mem_Rdy  (Mem_Rdy),
      .LD_MAR   (LD_MAR),
      .LD_MDR   (LD_MDR),
      .LD_IR    (LD_IR),
      .LD_BEN   (LD_BEN),
      .LD_CC    (LD_CC),
      .LD_REG   (LD_REG),
      .LD_PC    (LD_PC),
      .GatePC   (GatePC),
      .GateMDR  (GateMDR),
      .GateALU  (GateALU),
      .PCMUX    (PCMUX),
      .ALUK     (ALUK),
      .Mem_OE   (Mem_OE),
      .Paused   (Paused)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   localparam logic [15:0] O_LD_MAR  = 16'h8000;
   localparam logic [15:0] O_LD_MDR  = 16'h4000;
   localparam logic [15:0] O_LD_IR   = 16'h2000;
   localparam logic [15:0] O_LD_BEN  = 16'h1000;
   localparam logic [15:0] O_LD_CC   = 16'h0800;
   localparam logic [15:0] O_LD_REG  = 16'h0400;
   localparam logic [15:0] O_LD_PC   = 16'h0200;
   localparam logic [15:0] O_GPC     = 16'h0100;
   localparam logic [15:0] O_GMDR    = 16'h0080;
   localparam logic [15:0] O_GALU    = 16'h0040;
   localparam logic [15:0] O_PCM_OFF = 16'h0010;
   localparam logic [15:0] O_PCM_REG = 16'h0020;
   localparam logic [15:0] O_ALU_AND = 16'h0004;
   localparam logic [15:0] O_ALU_NOT = 16'h0008;
   localparam logic [15:0] O_MOE     = 16'h0002;
   localparam logic [15:0] O_PSD     = 16'h0001;

   typedef struct packed {
      logic [15:0] exp;
      logic        rst;
      logic        run_v;
      logic        run;
      logic        op_v;
      logic [3:0]  op;
      logic        ben_v;
      logic        ben;
      logic        rdy_v;
      logic        rdy;
      logic        cont_v;
      logic        cont;
   } cyc_t;

   cyc_t q[$];
   int   vec  = 0;
   int   miss = 0;

   function automatic cyc_t mk(input logic [15:0] e);
      cyc_t c;
      c     = '0;
      c.exp = e;
      return c;
   endfunction

   function automatic cyc_t mk_rdy(input logic [15:0] e, input logic r);
      cyc_t c;
      c       = mk(e);
      c.rdy_v = 1'b1;
      c.rdy   = r;
      return c;
   endfunction

   function automatic cyc_t mk_cont(input logic k);
      cyc_t c;
      c        = mk(O_PSD);
      c.cont_v = 1'b1;
      c.cont   = k;
      return c;
   endfunction

   function automatic cyc_t mk_halt(input logic r);
      cyc_t c;
      c       = mk(16'h0000);
      c.run_v = 1'b1;
      c.run   = r;
      return c;
   endfunction

   // Drive one cycle's inputs, sample outputs away from the edge, then move
   // to the next falling edge.
   task automatic step(input cyc_t c, output logic [15:0] obs);
      Reset    = c.rst;
      Run      = c.run_v  ? c.run  : 1'($urandom);
      Opcode   = c.op_v   ? c.op   : 4'($urandom);
      BEN      = c.ben_v  ? c.ben  : 1'($urandom);
      Mem_Rdy  = c.rdy_v  ? c.rdy  : 1'($urandom);
      Continue = c.cont_v ? c.cont : 1'($urandom);
      #1;
      obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
             GatePC, GateMDR, GateALU, PCMUX, ALUK, Mem_OE, Paused};
      @(negedge Clk);
   endtask

   task automatic reset_dut();
      Reset = 1'b1;
      Run   = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   // Expected cycles of one instruction from FETCH1 until the next FETCH1.
   task automatic push_instr(input logic [3:0] op, input int w, input logic ben,
                             input int n1, input int n2);
      cyc_t c;
      q.push_back(mk(O_GPC | O_LD_MAR | O_LD_PC));
      for (int i = 0; i < w; i++) q.push_back(mk_rdy(O_MOE, 1'b0));
      q.push_back(mk_rdy(O_MOE | O_LD_MDR, 1'b1));
      q.push_back(mk(O_GMDR | O_LD_IR));
      c      = mk(O_LD_BEN);
      c.op_v = 1'b1;
      c.op   = op;
      q.push_back(c);
      case (op)
         4'b0001: q.push_back(mk(O_GALU | O_LD_REG | O_LD_CC));
         4'b0101: q.push_back(mk(O_GALU | O_LD_REG | O_LD_CC | O_ALU_AND));
         4'b1001: q.push_back(mk(O_GALU | O_LD_REG | O_LD_CC | O_ALU_NOT));
         4'b1100: q.push_back(mk(O_LD_PC | O_PCM_REG));
         4'b0000: begin
            c       = mk(16'h0000);
            c.ben_v = 1'b1;
            c.ben   = ben;
            q.push_back(c);
            if (ben) q.push_back(mk(O_LD_PC | O_PCM_OFF));
         end
`ifdef PAUSE_OP_EN
         4'b1101: begin
            for (int i = 0; i < n1; i++) q.push_back(mk_cont(1'b0));
            q.push_back(mk_cont(1'b1));
            for (int i = 0; i < n2; i++) q.push_back(mk_cont(1'b1));
            q.push_back(mk_cont(1'b0));
         end
`endif
         default: ;
      endcase
   endtask

   task automatic test_reset();
      logic [15:0] obs;
      Reset = 1'b1;
      Run   = 1'b0;
      @(negedge Clk);
      q.delete();
      c_push_reset_body();
      foreach (q[i]) begin
         step(q[i], obs);
         vec++;
         if (obs !== q[i].exp) begin
            miss++;
            $display("FAIL reset cyc %0d: got %h want %h", i, obs, q[i].exp);
         end
      end
   endtask

   task automatic c_push_reset_body();
      cyc_t c;
      c       = mk_halt(1'b0);
      c.rst   = 1'b1;
      q.push_back(c);
      for (int i = 0; i < 5; i++) q.push_back(mk_halt(1'b0));
   endtask

   task automatic test_add();
      logic [15:0] obs;
      reset_dut();
      q.delete();
      q.push_back(mk_halt(1'b1));
      push_instr(4'b0001, 3, 1'b0, 0, 0);
      q.push_back(mk(O_GPC | O_LD_MAR | O_LD_PC));
      foreach (q[i]) begin
         step(q[i], obs);
         vec++;
         if (obs !== q[i].exp) begin
            miss++;
            $display("FAIL add cyc %0d: got %h want %h", i, obs, q[i].exp);
         end
      end
   endtask

   task automatic test_branch();
      logic [15:0] obs;
      reset_dut();
      q.delete();
      q.push_back(mk_halt(1'b1));
      push_instr(4'b0000, 1, 1'b1, 0, 0);
      push_instr(4'b0000, 0, 1'b0, 0, 0);
      push_instr(4'b1100, 2, 1'b0, 0, 0);
      q.push_back(mk(O_GPC | O_LD_MAR | O_LD_PC));
      foreach (q[i]) begin
         step(q[i], obs);
         vec++;
         if (obs !== q[i].exp) begin
            miss++;
            $display("FAIL branch cyc %0d: got %h want %h", i, obs, q[i].exp);
         end
      end
   endtask

   task automatic test_unsupported();
      logic [15:0] obs;
      reset_dut();
      q.delete();
      q.push_back(mk_halt(1'b1));
      push_instr(4'b0111, 0, 1'b0, 0, 0);
      push_instr(4'b1111, 1, 1'b0, 0, 0);
      push_instr(4'b0101, 0, 1'b0, 0, 0);
      push_instr(4'b1001, 2, 1'b0, 0, 0);
      q.push_back(mk(O_GPC | O_LD_MAR | O_LD_PC));
      foreach (q[i]) begin
         step(q[i], obs);
         vec++;
         if (obs !== q[i].exp) begin
            miss++;
            $display("FAIL unsupported cyc %0d: got %h want %h", i, obs, q[i].exp);
         end
      end
   endtask

   task automatic test_pause();
      logic [15:0] obs;
      cyc_t        c;
      reset_dut();
      q.delete();
      q.push_back(mk_halt(1'b1));
      push_instr(4'b1101, 0, 1'b0, 2, 3);
      push_instr(4'b1101, 1, 1'b0, 0, 0);
      push_instr(4'b0001, 0, 1'b0, 0, 0);
`ifdef PAUSE_OP_EN
      // Reset while parked in PAUSE1 must return to HALTED.
      push_instr(4'b1101, 0, 1'b0, 0, 0);
      void'(q.pop_back());
      void'(q.pop_back());
      c      = mk_cont(1'b0);
      c.rst  = 1'b1;
      q.push_back(c);
      q.push_back(mk_halt(1'b0));
      q.push_back(mk_halt(1'b0));
`else
      c = mk(O_GPC | O_LD_MAR | O_LD_PC);
      q.push_back(c);
`endif
      foreach (q[i]) begin
         step(q[i], obs);
         vec++;
         if (obs !== q[i].exp) begin
            miss++;
            $display("FAIL pause cyc %0d: got %h want %h", i, obs, q[i].exp);
         end
      end
   endtask

   task automatic test_reset_mid_fetch();
      logic [15:0] obs;
      cyc_t        c;
      reset_dut();
      q.delete();
      q.push_back(mk_halt(1'b1));
      q.push_back(mk(O_GPC | O_LD_MAR | O_LD_PC));
      q.push_back(mk_rdy(O_MOE, 1'b0));
      c     = mk_rdy(O_MOE, 1'b0);
      c.rst = 1'b1;
      q.push_back(c);
      q.push_back(mk_halt(1'b0));
      q.push_back(mk_halt(1'b0));
      q.push_back(mk_halt(1'b1));
      q.push_back(mk(O_GPC | O_LD_MAR | O_LD_PC));
      foreach (q[i]) begin
         step(q[i], obs);
         vec++;
         if (obs !== q[i].exp) begin
            miss++;
            $display("FAIL reset_mid cyc %0d: got %h want %h", i, obs, q[i].exp);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] obs;
      reset_dut();
      q.delete();
      q.push_back(mk_halt(1'b1));
      for (int n = 0; n < 60; n++)
         push_instr(4'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
                    1'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
      q.push_back(mk(O_GPC | O_LD_MAR | O_LD_PC));
      foreach (q[i]) begin
         step(q[i], obs);
         vec++;
         if (obs !== q[i].exp) begin
            miss++;
            $display("FAIL random cyc %0d: got %h want %h", i, obs, q[i].exp);
         end
      end
   endtask

   initial begin
      Reset    = 1'b1;
      Run      = 1'b0;
      Continue = 1'b0;
      Opcode   = 4'h0;
      BEN      = 1'b0;
      Mem_Rdy  = 1'b0;
      test_reset();
      test_add();
      test_branch();
      test_unsupported();
      test_pause();
      test_reset_mid_fetch();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
